bp_be_dcache_fill_engine: RTL and testbench

BP_BE_DCACHE_FILL_ENGINE -- requirements
Module: bp_be_dcache_fill_engine

---
 rtl/bp_be_dcache_fill_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bp_be_dcache_fill_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_dcache_fill_engine
// Purpose  : D$ miss/uncached request engine. Issues block-read or uncached
//            memory commands, streams fill beats into the data array, then
//            writes the tag and touches the stat array for cached misses.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_dcache_fill_engine #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int fill_width_p  = 128,
  parameter int dword_width_p = 64,
  localparam int LG_SETS      = $clog2(sets_p),
  localparam int LG_ASSOC     = $clog2(assoc_p),
  localparam int BLOCK_OFFSET = $clog2(block_width_p / 8),
  localparam int BEATS        = block_width_p / fill_width_p,
  localparam int LG_BEATS     = $clog2(BEATS),
  localparam int BEAT_OFFSET  = $clog2(fill_width_p / 8),
  localparam int TAG_WIDTH    = paddr_width_p - LG_SETS - BLOCK_OFFSET
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     cache_req_v_i,
  output logic                     cache_req_ready_o,
  input  logic [1:0]               cache_req_type_i,
  input  logic [paddr_width_p-1:0] cache_req_addr_i,
  input  logic [dword_width_p-1:0] cache_req_data_i,
  input  logic                     cache_req_metadata_v_i,
  input  logic [LG_ASSOC-1:0]      cache_req_repl_way_i,

  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  output logic [1:0]               mem_cmd_type_o,
  output logic [paddr_width_p-1:0] mem_cmd_addr_o,
  output logic [dword_width_p-1:0] mem_cmd_data_o,

  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  input  logic [fill_width_p-1:0]  mem_resp_data_i,

  output logic                     data_mem_pkt_v_o,
  input  logic                     data_mem_pkt_yumi_i,
  output logic [LG_SETS-1:0]       data_mem_pkt_index_o,
  output logic [LG_ASSOC-1:0]      data_mem_pkt_way_o,
  output logic [LG_BEATS-1:0]      data_mem_pkt_fill_idx_o,
  output logic                     data_mem_pkt_uncached_o,
  output logic [fill_width_p-1:0]  data_mem_pkt_data_o,

  output logic                     tag_mem_pkt_v_o,
  input  logic                     tag_mem_pkt_yumi_i,
  output logic [LG_SETS-1:0]       tag_mem_pkt_index_o,
  output logic [LG_ASSOC-1:0]      tag_mem_pkt_way_o,
  output logic [TAG_WIDTH-1:0]     tag_mem_pkt_tag_o,
  output logic [1:0]               tag_mem_pkt_state_o,

  output logic                     stat_mem_pkt_v_o,
  input  logic                     stat_mem_pkt_yumi_i,
  output logic [LG_SETS-1:0]       stat_mem_pkt_index_o,
  output logic [LG_ASSOC-1:0]      stat_mem_pkt_way_o,

  output logic                     cache_req_critical_o,
  output logic                     cache_req_complete_o
);

  localparam logic [1:0] REQ_MISS_LOAD  = 2'd0;
  localparam logic [1:0] REQ_MISS_STORE = 2'd1;
  localparam logic [1:0] REQ_UC_LOAD    = 2'd2;
  localparam logic [1:0] REQ_UC_STORE   = 2'd3;

  localparam logic [1:0] CMD_BLOCK_READ = 2'd0;
  localparam logic [1:0] CMD_UC_READ    = 2'd1;
  localparam logic [1:0] CMD_UC_WRITE   = 2'd2;

  localparam logic [1:0] TAG_STATE_CLEAN = 2'b01;
  localparam logic [1:0] TAG_STATE_DIRTY = 2'b10;

  localparam logic [LG_BEATS-1:0] LAST_BEAT = LG_BEATS'(BEATS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_META    = 4'd1,
    S_CMD     = 4'd2,
    S_FILL    = 4'd3,
    S_TAG     = 4'd4,
    S_STAT    = 4'd5,
    S_UC_CMD  = 4'd6,
    S_UC_RESP = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  state_e                     state;
  logic [1:0]                 req_type;
  logic [paddr_width_p-1:0]   req_addr;
  logic [dword_width_p-1:0]   req_data;
  logic [LG_ASSOC-1:0]        req_way;
  logic [LG_BEATS-1:0]        beat_cnt;

  logic                       req_is_miss;
  logic                       beat_accept;
  logic                       uc_load_accept;
  logic [LG_SETS-1:0]         req_index;
  logic [LG_BEATS-1:0]        crit_beat;
  logic [paddr_width_p-1:0]   block_addr;

  // Request decode and address slicing shared by all packet fields
  assign req_is_miss    = ~cache_req_type_i[1];
  assign req_index      = req_addr[BLOCK_OFFSET+LG_SETS-1:BLOCK_OFFSET];
  assign crit_beat      = req_addr[BLOCK_OFFSET-1:BEAT_OFFSET];
  assign block_addr     = {req_addr[paddr_width_p-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
  assign beat_accept    = (state == S_FILL) & mem_resp_v_i & data_mem_pkt_yumi_i;
  assign uc_load_accept = (state == S_UC_RESP) & (req_type == REQ_UC_LOAD)
                        & mem_resp_v_i & data_mem_pkt_yumi_i;

  // Packet fields come straight from latched request state so they stay
  // constant while a valid waits for its handshake
  assign data_mem_pkt_index_o    = req_index;
  assign data_mem_pkt_way_o      = req_way;
  assign data_mem_pkt_fill_idx_o = beat_cnt;
  assign tag_mem_pkt_index_o     = req_index;
  assign tag_mem_pkt_way_o       = req_way;
  assign tag_mem_pkt_tag_o       = req_addr[paddr_width_p-1:paddr_width_p-TAG_WIDTH];
  assign tag_mem_pkt_state_o     = (req_type == REQ_MISS_STORE) ? TAG_STATE_DIRTY : TAG_STATE_CLEAN;
  assign stat_mem_pkt_index_o    = req_index;
  assign stat_mem_pkt_way_o      = req_way;

  // Transaction sequencer: request latch, beat counter and state transitions
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= S_IDLE;
      req_type <= REQ_MISS_LOAD;
      req_addr <= '0;
      req_data <= '0;
      req_way  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cache_req_v_i) begin
            req_type <= cache_req_type_i;
            req_addr <= cache_req_addr_i;
            req_data <= cache_req_data_i;
            if (req_is_miss) begin
              if (cache_req_metadata_v_i) begin
                req_way <= cache_req_repl_way_i;
                state   <= S_CMD;
              end else begin
                state   <= S_META;
              end
            end else begin
              state <= S_UC_CMD;
            end
          end
        end
        S_META: begin
          if (cache_req_metadata_v_i) begin
            req_way <= cache_req_repl_way_i;
            state   <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_cmd_ready_i) state <= S_FILL;
        end
        S_FILL: begin
          if (beat_accept) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= S_TAG;
            end else begin
              beat_cnt <= beat_cnt + LG_BEATS'(1);
            end
          end
        end
        S_TAG: begin
          if (tag_mem_pkt_yumi_i) state <= S_STAT;
        end
        S_STAT: begin
          if (stat_mem_pkt_yumi_i) state <= S_DONE;
        end
        S_UC_CMD: begin
          if (mem_cmd_ready_i) state <= S_UC_RESP;
        end
        S_UC_RESP: begin
          if (req_type == REQ_UC_LOAD) begin
            if (uc_load_accept) state <= S_DONE;
          end else if (mem_resp_v_i) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded from the current state; at most one array valid
  always_comb begin
    cache_req_ready_o       = (state == S_IDLE);
    mem_cmd_v_o             = 1'b0;
    mem_cmd_type_o          = CMD_BLOCK_READ;
    mem_cmd_addr_o          = '0;
    mem_cmd_data_o          = '0;
    mem_resp_yumi_o         = 1'b0;
    data_mem_pkt_v_o        = 1'b0;
    data_mem_pkt_uncached_o = 1'b0;
    data_mem_pkt_data_o     = '0;
    tag_mem_pkt_v_o         = 1'b0;
    stat_mem_pkt_v_o        = 1'b0;
    cache_req_critical_o    = 1'b0;
    cache_req_complete_o    = 1'b0;
    case (state)
      S_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_type_o = CMD_BLOCK_READ;
        mem_cmd_addr_o = block_addr;
      end
      S_FILL: begin
        data_mem_pkt_v_o     = mem_resp_v_i;
        data_mem_pkt_data_o  = mem_resp_data_i;
        mem_resp_yumi_o      = beat_accept;
        cache_req_critical_o = beat_accept & (beat_cnt == crit_beat);
      end
      S_TAG: begin
        tag_mem_pkt_v_o = 1'b1;
      end
      S_STAT: begin
        stat_mem_pkt_v_o = 1'b1;
      end
      S_UC_CMD: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_type_o = (req_type == REQ_UC_LOAD) ? CMD_UC_READ : CMD_UC_WRITE;
        mem_cmd_addr_o = req_addr;
        mem_cmd_data_o = req_data;
      end
      S_UC_RESP: begin
        if (req_type == REQ_UC_LOAD) begin
          data_mem_pkt_v_o        = mem_resp_v_i;
          data_mem_pkt_uncached_o = 1'b1;
          data_mem_pkt_data_o     = fill_width_p'(mem_resp_data_i[dword_width_p-1:0]);
          mem_resp_yumi_o         = uc_load_accept;
          cache_req_critical_o    = uc_load_accept;
        end else begin
          // Store acknowledgement carries no data; just retire it
          mem_resp_yumi_o = mem_resp_v_i;
        end
      end
      S_DONE: begin
        cache_req_complete_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_dcache_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_dcache_fill_engine
// Purpose  : Directed self-checking bench for bp_be_dcache_fill_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_be_dcache_fill_engine;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         cache_req_v_i = 1'b0;
  logic         cache_req_ready_o;
  logic [1:0]   cache_req_type_i = 2'd0;
  logic [39:0]  cache_req_addr_i = '0;
  logic [63:0]  cache_req_data_i = '0;
  logic         cache_req_metadata_v_i = 1'b0;
  logic [2:0]   cache_req_repl_way_i = '0;
  logic         mem_cmd_v_o;
  logic         mem_cmd_ready_i = 1'b0;
  logic [1:0]   mem_cmd_type_o;
  logic [39:0]  mem_cmd_addr_o;
  logic [63:0]  mem_cmd_data_o;
  logic         mem_resp_v_i = 1'b0;
  logic         mem_resp_yumi_o;
  logic [127:0] mem_resp_data_i = '0;
  logic         data_mem_pkt_v_o;
  logic         data_mem_pkt_yumi_i = 1'b0;
  logic [5:0]   data_mem_pkt_index_o;
  logic [2:0]   data_mem_pkt_way_o;
  logic [1:0]   data_mem_pkt_fill_idx_o;
  logic         data_mem_pkt_uncached_o;
  logic [127:0] data_mem_pkt_data_o;
  logic         tag_mem_pkt_v_o;
  logic         tag_mem_pkt_yumi_i = 1'b0;
  logic [5:0]   tag_mem_pkt_index_o;
  logic [2:0]   tag_mem_pkt_way_o;
  logic [27:0]  tag_mem_pkt_tag_o;
  logic [1:0]   tag_mem_pkt_state_o;
  logic         stat_mem_pkt_v_o;
  logic         stat_mem_pkt_yumi_i = 1'b0;
  logic [5:0]   stat_mem_pkt_index_o;
  logic [2:0]   stat_mem_pkt_way_o;
  logic         cache_req_critical_o;
  logic         cache_req_complete_o;

  int tests_run = 0;
  int tests_failed = 0;

  bp_be_dcache_fill_engine dut (
    .clk_i                   (clk_i),
    .reset_i                 (reset_i),
    .cache_req_v_i           (cache_req_v_i),
    .cache_req_ready_o       (cache_req_ready_o),
    .cache_req_type_i        (cache_req_type_i),
    .cache_req_addr_i        (cache_req_addr_i),
    .cache_req_data_i        (cache_req_data_i),
    .cache_req_metadata_v_i  (cache_req_metadata_v_i),
    .cache_req_repl_way_i    (cache_req_repl_way_i),
    .mem_cmd_v_o             (mem_cmd_v_o),
    .mem_cmd_ready_i         (mem_cmd_ready_i),
    .mem_cmd_type_o          (mem_cmd_type_o),
    .mem_cmd_addr_o          (mem_cmd_addr_o),
    .mem_cmd_data_o          (mem_cmd_data_o),
    .mem_resp_v_i            (mem_resp_v_i),
    .mem_resp_yumi_o         (mem_resp_yumi_o),
    .mem_resp_data_i         (mem_resp_data_i),
    .data_mem_pkt_v_o        (data_mem_pkt_v_o),
    .data_mem_pkt_yumi_i     (data_mem_pkt_yumi_i),
    .data_mem_pkt_index_o    (data_mem_pkt_index_o),
    .data_mem_pkt_way_o      (data_mem_pkt_way_o),
    .data_mem_pkt_fill_idx_o (data_mem_pkt_fill_idx_o),
    .data_mem_pkt_uncached_o (data_mem_pkt_uncached_o),
    .data_mem_pkt_data_o     (data_mem_pkt_data_o),
    .tag_mem_pkt_v_o         (tag_mem_pkt_v_o),
    .tag_mem_pkt_yumi_i      (tag_mem_pkt_yumi_i),
    .tag_mem_pkt_index_o     (tag_mem_pkt_index_o),
    .tag_mem_pkt_way_o       (tag_mem_pkt_way_o),
    .tag_mem_pkt_tag_o       (tag_mem_pkt_tag_o),
    .tag_mem_pkt_state_o     (tag_mem_pkt_state_o),
    .stat_mem_pkt_v_o        (stat_mem_pkt_v_o),
    .stat_mem_pkt_yumi_i     (stat_mem_pkt_yumi_i),
    .stat_mem_pkt_index_o    (stat_mem_pkt_index_o),
    .stat_mem_pkt_way_o      (stat_mem_pkt_way_o),
    .cache_req_critical_o    (cache_req_critical_o),
    .cache_req_complete_o    (cache_req_complete_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [127:0] beat_data(input int b);
    return {32'hA000_0000 + 32'(b), 32'h1111_2222, 32'h3333_4444, 32'(b) + 32'h50};
  endfunction

  // Drives four beats starting in FILL; one beat may be stalled by the data array
  task automatic run_fill(input logic [5:0] idx, input logic [2:0] way, input int crit,
                          input int stall_beat, input int stall_n);
    for (int b = 0; b < 4; b++) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_data_i = beat_data(b);
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          data_mem_pkt_yumi_i = 1'b0;
          #1;
          check("stall_data_v", 128'(data_mem_pkt_v_o), 128'd1);
          check("stall_resp_yumi", 128'(mem_resp_yumi_o), 128'd0);
          check("stall_fill_idx", 128'(data_mem_pkt_fill_idx_o), 128'(b));
          check("stall_data", data_mem_pkt_data_o, beat_data(b));
          check("stall_crit", 128'(cache_req_critical_o), 128'd0);
          tick();
        end
      end
      data_mem_pkt_yumi_i = 1'b1;
      #1;
      check("fill_data_v", 128'(data_mem_pkt_v_o), 128'd1);
      check("fill_resp_yumi", 128'(mem_resp_yumi_o), 128'd1);
      check("fill_idx", 128'(data_mem_pkt_fill_idx_o), 128'(b));
      check("fill_index", 128'(data_mem_pkt_index_o), 128'(idx));
      check("fill_way", 128'(data_mem_pkt_way_o), 128'(way));
      check("fill_uncached", 128'(data_mem_pkt_uncached_o), 128'd0);
      check("fill_data", data_mem_pkt_data_o, beat_data(b));
      check("fill_crit", 128'(cache_req_critical_o), 128'(b == crit));
      check("fill_tag_v", 128'(tag_mem_pkt_v_o), 128'd0);
      tick();
    end
    mem_resp_v_i        = 1'b0;
    data_mem_pkt_yumi_i = 1'b0;
  endtask

  // TAG (held one cycle before yumi), STAT, DONE, back to IDLE
  task automatic run_tag_stat(input logic [5:0] idx, input logic [2:0] way,
                              input logic [27:0] tag, input logic [1:0] st);
    #1;
    check("tag_v", 128'(tag_mem_pkt_v_o), 128'd1);
    check("tag_data_v", 128'(data_mem_pkt_v_o), 128'd0);
    check("tag_stat_v", 128'(stat_mem_pkt_v_o), 128'd0);
    check("tag_index", 128'(tag_mem_pkt_index_o), 128'(idx));
    check("tag_way", 128'(tag_mem_pkt_way_o), 128'(way));
    check("tag_tag", 128'(tag_mem_pkt_tag_o), 128'(tag));
    check("tag_state", 128'(tag_mem_pkt_state_o), 128'(st));
    tick();
    #1;
    check("tag_hold_v", 128'(tag_mem_pkt_v_o), 128'd1);
    check("tag_hold_tag", 128'(tag_mem_pkt_tag_o), 128'(tag));
    tag_mem_pkt_yumi_i = 1'b1;
    tick();
    tag_mem_pkt_yumi_i = 1'b0;
    #1;
    check("stat_v", 128'(stat_mem_pkt_v_o), 128'd1);
    check("stat_tag_v", 128'(tag_mem_pkt_v_o), 128'd0);
    check("stat_index", 128'(stat_mem_pkt_index_o), 128'(idx));
    check("stat_way", 128'(stat_mem_pkt_way_o), 128'(way));
    stat_mem_pkt_yumi_i = 1'b1;
    check("stat_complete", 128'(cache_req_complete_o), 128'd0);
    tick();
    stat_mem_pkt_yumi_i = 1'b0;
    #1;
    check("done_complete", 128'(cache_req_complete_o), 128'd1);
    check("done_ready", 128'(cache_req_ready_o), 128'd0);
    check("done_stat_v", 128'(stat_mem_pkt_v_o), 128'd0);
    tick();
    #1;
    check("idle_complete", 128'(cache_req_complete_o), 128'd0);
    check("idle_ready", 128'(cache_req_ready_o), 128'd1);
  endtask

  // Uncached store from IDLE through completion
  task automatic run_uc_store(input logic [39:0] addr, input logic [63:0] data);
    cache_req_v_i    = 1'b1;
    cache_req_type_i = 2'd3;
    cache_req_addr_i = addr;
    cache_req_data_i = data;
    #1;
    check("ucs_accept_ready", 128'(cache_req_ready_o), 128'd1);
    tick();
    cache_req_v_i = 1'b0;
    #1;
    check("ucs_cmd_v", 128'(mem_cmd_v_o), 128'd1);
    check("ucs_cmd_type", 128'(mem_cmd_type_o), 128'd2);
    check("ucs_cmd_addr", 128'(mem_cmd_addr_o), 128'(addr));
    check("ucs_cmd_data", 128'(mem_cmd_data_o), 128'(data));
    mem_cmd_ready_i = 1'b1;
    tick();
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b1;
    mem_resp_data_i = 128'hFFFF;
    #1;
    check("ucs_cmd_v_drop", 128'(mem_cmd_v_o), 128'd0);
    check("ucs_resp_yumi", 128'(mem_resp_yumi_o), 128'd1);
    check("ucs_pkt_v", 128'({data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o}), 128'd0);
    check("ucs_complete_early", 128'(cache_req_complete_o), 128'd0);
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    check("ucs_complete", 128'(cache_req_complete_o), 128'd1);
    tick();
    #1;
    check("ucs_idle_ready", 128'(cache_req_ready_o), 128'd1);
  endtask

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    #1;
    check("rst_ready_in_reset", 128'(cache_req_ready_o), 128'd1);
    check("rst_cmd_v", 128'(mem_cmd_v_o), 128'd0);
    tick();
    reset_i = 1'b1;
    #1;
    check("rst_ready", 128'(cache_req_ready_o), 128'd1);
    check("rst_valids", 128'({mem_cmd_v_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o}), 128'd0);
    check("rst_pulses", 128'({cache_req_critical_o, cache_req_complete_o, mem_resp_yumi_o}), 128'd0);
    check("rst_fill_idx", 128'(data_mem_pkt_fill_idx_o), 128'd0);
    tick();

    // ---------------- miss_load, metadata same cycle ----------------
    cache_req_v_i          = 1'b1;
    cache_req_type_i       = 2'd0;
    cache_req_addr_i       = 40'h80001234;
    cache_req_metadata_v_i = 1'b1;
    cache_req_repl_way_i   = 3'd5;
    #1;
    check("ml_accept_ready", 128'(cache_req_ready_o), 128'd1);
    tick();
    cache_req_v_i          = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    mem_resp_v_i           = 1'b1;
    #1;
    check("ml_cmd_v", 128'(mem_cmd_v_o), 128'd1);
    check("ml_cmd_type", 128'(mem_cmd_type_o), 128'd0);
    check("ml_cmd_addr", 128'(mem_cmd_addr_o), 128'h80001200);
    check("ml_ready_busy", 128'(cache_req_ready_o), 128'd0);
    check("ml_cmd_resp_yumi", 128'(mem_resp_yumi_o), 128'd0);
    mem_cmd_ready_i = 1'b1;
    tick();
    mem_cmd_ready_i = 1'b0;
    run_fill(6'h08, 3'd5, 3, -1, 0);
    run_tag_stat(6'h08, 3'd5, 28'h80001, 2'b01);

    // ---------------- miss_store, metadata late, stall on beat 1 ----------------
    cache_req_v_i    = 1'b1;
    cache_req_type_i = 2'd1;
    cache_req_addr_i = 40'h00ABCDE7C0;
    tick();
    cache_req_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ms_meta_cmd_v", 128'(mem_cmd_v_o), 128'd0);
      check("ms_meta_ready", 128'(cache_req_ready_o), 128'd0);
      tick();
    end
    cache_req_metadata_v_i = 1'b1;
    cache_req_repl_way_i   = 3'd2;
    #1;
    check("ms_meta_now_cmd_v", 128'(mem_cmd_v_o), 128'd0);
    tick();
    // metadata seen in CMD must not alter the latched way
    cache_req_repl_way_i = 3'd7;
    #1;
    check("ms_cmd_v", 128'(mem_cmd_v_o), 128'd1);
    check("ms_cmd_addr", 128'(mem_cmd_addr_o), 128'hABCDE7C0);
    mem_cmd_ready_i = 1'b1;
    tick();
    mem_cmd_ready_i        = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    run_fill(6'h1F, 3'd2, 0, 1, 5);
    run_tag_stat(6'h1F, 3'd2, 28'hABCDE, 2'b10);

    // ---------------- uc_load ----------------
    cache_req_v_i    = 1'b1;
    cache_req_type_i = 2'd2;
    cache_req_addr_i = 40'h10;
    tick();
    cache_req_v_i = 1'b0;
    #1;
    check("ucl_cmd_v", 128'(mem_cmd_v_o), 128'd1);
    check("ucl_cmd_type", 128'(mem_cmd_type_o), 128'd1);
    check("ucl_cmd_addr", 128'(mem_cmd_addr_o), 128'h10);
    mem_cmd_ready_i = 1'b1;
    tick();
    mem_cmd_ready_i     = 1'b0;
    mem_resp_v_i        = 1'b1;
    mem_resp_data_i     = {64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001};
    data_mem_pkt_yumi_i = 1'b0;
    #1;
    check("ucl_pkt_v", 128'(data_mem_pkt_v_o), 128'd1);
    check("ucl_uncached", 128'(data_mem_pkt_uncached_o), 128'd1);
    check("ucl_data", data_mem_pkt_data_o, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0001);
    check("ucl_wait_yumi", 128'(mem_resp_yumi_o), 128'd0);
    check("ucl_wait_crit", 128'(cache_req_critical_o), 128'd0);
    tick();
    data_mem_pkt_yumi_i = 1'b1;
    #1;
    check("ucl_crit", 128'(cache_req_critical_o), 128'd1);
    check("ucl_resp_yumi", 128'(mem_resp_yumi_o), 128'd1);
    check("ucl_crit_not_complete", 128'(cache_req_complete_o), 128'd0);
    tick();
    mem_resp_v_i        = 1'b0;
    data_mem_pkt_yumi_i = 1'b0;
    #1;
    check("ucl_complete", 128'(cache_req_complete_o), 128'd1);
    check("ucl_complete_not_crit", 128'(cache_req_critical_o), 128'd0);
    tick();
    #1;
    check("ucl_idle", 128'({cache_req_ready_o, cache_req_complete_o}), 128'b10);

    // ---------------- uc_store ----------------
    run_uc_store(40'h20, 64'h55);

    // ---------------- reset during FILL beat 2 ----------------
    cache_req_v_i          = 1'b1;
    cache_req_type_i       = 2'd0;
    cache_req_addr_i       = 40'h80001234;
    cache_req_metadata_v_i = 1'b1;
    cache_req_repl_way_i   = 3'd5;
    tick();
    cache_req_v_i          = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    mem_cmd_ready_i        = 1'b1;
    tick();
    mem_cmd_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_v_i        = 1'b1;
      mem_resp_data_i     = beat_data(b);
      data_mem_pkt_yumi_i = 1'b1;
      tick();
    end
    data_mem_pkt_yumi_i = 1'b0;
    #1;
    check("rstf_beat2_idx", 128'(data_mem_pkt_fill_idx_o), 128'd2);
    reset_i = 1'b0;
    #1;
    check("rstf_ready", 128'(cache_req_ready_o), 128'd1);
    check("rstf_valids", 128'({mem_cmd_v_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o}), 128'd0);
    check("rstf_resp_yumi", 128'(mem_resp_yumi_o), 128'd0);
    check("rstf_fill_idx", 128'(data_mem_pkt_fill_idx_o), 128'd0);
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    check("rstf_no_complete", 128'(cache_req_complete_o), 128'd0);
    reset_i = 1'b1;
    tick();
    #1;
    check("rstf_post_complete", 128'(cache_req_complete_o), 128'd0);
    run_uc_store(40'h48, 64'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
